// File: rtl/bkd_pkg.sv
// ============================================================================
// Module  : bkd_pkg
// Brief   : Shared types and constants for the backend packet arbiter path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bkd_pkg;

  localparam int DATA_W        = 64;
  localparam int STRB_W        = 8;
  localparam int USER_W        = 128;
  localparam int TUSER_LEN_MSB = 15;

  localparam logic [7:0] PORT_ID0 = 8'h00;
  localparam logic [7:0] PORT_ID1 = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_GNT0 = 3'b010,
    ST_GNT1 = 3'b100
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } axis_beat_t;

  // Replace the 8-bit field at lsb with id; every other user bit is kept.
  function automatic logic [USER_W-1:0] stamp_port_id(
    input logic [USER_W-1:0] user,
    input int unsigned       lsb,
    input logic [7:0]        id
  );
    logic [USER_W-1:0] w_mask;
    logic [USER_W-1:0] w_ins;
    w_mask = {{(USER_W-8){1'b0}}, 8'hFF} << lsb;
    w_ins  = {{(USER_W-8){1'b0}}, id} << lsb;
    return (user & ~w_mask) | w_ins;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
// ============================================================================
// Module  : axis_reg_slice
// Brief   : Single-stage AXI4-Stream register slice (ready = empty or drained).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_reg_slice
  import bkd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_s_tvalid,
  output logic       o_s_tready,
  input  axis_beat_t i_s_beat,
  output logic       o_m_tvalid,
  output axis_beat_t o_m_beat,
  input  logic       i_m_tready
);

  logic       r_valid;
  axis_beat_t r_beat;
  logic       w_s_tready;

  assign w_s_tready = !r_valid || i_m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_s_tvalid && w_s_tready) begin
      r_valid <= 1'b1;
      r_beat  <= i_s_beat;
    end else if (i_m_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_s_tready = w_s_tready;
  assign o_m_tvalid = r_valid;
  assign o_m_beat   = r_beat;

endmodule

`default_nettype wire

// File: rtl/bkd_pkt_arb.sv
// ============================================================================
// Module  : bkd_pkt_arb
// Brief   : Packet-granular round-robin arbiter of two AXIS readers onto one
//           registered backend TX port; tuser stamped with the source port.
//           Optional packet counters: define BKD_PKT_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bkd_pkt_arb
  import bkd_pkg::*;
#(
  parameter int PORT_ID_LSB = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [STRB_W-1:0] s0_axis_tstrb,
  input  logic [USER_W-1:0] s0_axis_tuser,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [STRB_W-1:0] s1_axis_tstrb,
  input  logic [USER_W-1:0] s1_axis_tuser,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [STRB_W-1:0] m_axis_tstrb,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [31:0]       pkt_cnt0,
  output logic [31:0]       pkt_cnt1
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last_served;
  logic       w_slice_rdy;
  logic       w_sel_valid;
  axis_beat_t w_sel_beat;
  axis_beat_t w_m_beat;
  logic       w_done0;
  logic       w_done1;

  // tready is only ever high for the granted port, so these mark end of packet.
  assign w_done0 = s0_axis_tvalid && s0_axis_tready && s0_axis_tlast;
  assign w_done1 = s1_axis_tvalid && s1_axis_tready && s1_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_served <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_done0) r_last_served <= 1'b0;
      else if (w_done1) r_last_served <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid)
          w_state_nxt = r_last_served ? ST_GNT0 : ST_GNT1;
        else if (s0_axis_tvalid)
          w_state_nxt = ST_GNT0;
        else if (s1_axis_tvalid)
          w_state_nxt = ST_GNT1;
      end
      ST_GNT0: if (w_done0) w_state_nxt = ST_IDLE;
      ST_GNT1: if (w_done1) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    w_sel_valid    = 1'b0;
    w_sel_beat     = '0;
    case (r_state)
      ST_GNT0: begin
        s0_axis_tready   = w_slice_rdy;
        w_sel_valid      = s0_axis_tvalid;
        w_sel_beat.tdata = s0_axis_tdata;
        w_sel_beat.tstrb = s0_axis_tstrb;
        w_sel_beat.tuser = stamp_port_id(s0_axis_tuser, PORT_ID_LSB, PORT_ID0);
        w_sel_beat.tlast = s0_axis_tlast;
      end
      ST_GNT1: begin
        s1_axis_tready   = w_slice_rdy;
        w_sel_valid      = s1_axis_tvalid;
        w_sel_beat.tdata = s1_axis_tdata;
        w_sel_beat.tstrb = s1_axis_tstrb;
        w_sel_beat.tuser = stamp_port_id(s1_axis_tuser, PORT_ID_LSB, PORT_ID1);
        w_sel_beat.tlast = s1_axis_tlast;
      end
      default: ;
    endcase
  end

  axis_reg_slice u_out_slice (
    .clk        (clk),
    .rst        (rst),
    .i_s_tvalid (w_sel_valid),
    .o_s_tready (w_slice_rdy),
    .i_s_beat   (w_sel_beat),
    .o_m_tvalid (m_axis_tvalid),
    .o_m_beat   (w_m_beat),
    .i_m_tready (m_axis_tready)
  );

  assign m_axis_tdata = w_m_beat.tdata;
  assign m_axis_tstrb = w_m_beat.tstrb;
  assign m_axis_tuser = w_m_beat.tuser;
  assign m_axis_tlast = w_m_beat.tlast;

`ifdef BKD_PKT_ARB_STATS_EN
  logic [31:0] r_cnt0;
  logic [31:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= 32'h0;
      r_cnt1 <= 32'h0;
    end else begin
      if (w_done0) r_cnt0 <= r_cnt0 + 32'd1;
      if (w_done1) r_cnt1 <= r_cnt1 + 32'd1;
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
`else
  assign pkt_cnt0 = 32'h0;
  assign pkt_cnt1 = 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/bkd_pkt_arb.md
Name: bkd_pkt_arb

Overview:
- Packet-granular round-robin arbiter that shares the single backend AXI4-Stream TX port between two ibuf-to-backend readers (port 0, port 1).
- Grant is held for a whole packet, from first beat through tlast; packets are never interleaved.
- The output is a registered single-stage slice toward the backend, with tuser stamped with the source port.

Parameters:
- PORT_ID_LSB, 16, bit position in m_axis_tuser where the 8-bit source port id is written (bits [PORT_ID_LSB+7:PORT_ID_LSB]).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- s0_axis_tdata  in  64  port 0 data
- s0_axis_tstrb  in  8  port 0 byte strobes
- s0_axis_tuser  in  128  port 0 user; [15:0] = packet length
- s0_axis_tvalid  in  1  port 0 valid
- s0_axis_tlast  in  1  port 0 last beat
- s0_axis_tready  out  1  port 0 ready
- s1_axis_*  same widths/directions as s0_axis_*, port 1
- m_axis_tdata  out  64  backend data
- m_axis_tstrb  out  8  backend strobes
- m_axis_tuser  out  128  backend user, with port id stamped
- m_axis_tvalid  out  1  backend valid
- m_axis_tlast  out  1  backend last
- m_axis_tready  in  1  backend ready
- pkt_cnt0  out  32  packets forwarded from port 0 (see Optional Feature)
- pkt_cnt1  out  32  packets forwarded from port 1

Behaviour:
Reset (synchronous, rst=1 at clk edge):
- All outputs are 0, including m_axis_tvalid, m_axis_tlast, s0/s1_axis_tready and the counters.
- The FSM goes to IDLE and last_served=1, so port 0 wins the first tie.
- A reset mid-packet drops the partial packet with no flush and no tlast; the bench must not expect recovery of that packet.

FSM states: IDLE, GNT0, GNT1.
- IDLE: s*_axis_tready=0.
  - Only s0 valid -> GNT0; only s1 valid -> GNT1.
  - Both valid -> the port other than last_served.
  - Neither -> stay in IDLE.
  - tvalid is sampled at the IDLE cycle edge; the grant is registered.
- GNTx: sx_axis_tready = (!m_axis_tvalid || m_axis_tready), combinational from the output register state; the other port's tready=0.
  - On an accepted beat (sx tvalid && sx tready), the output register loads tdata/tstrb/tlast/tuser and sets m_axis_tvalid=1.
  - m_axis_tuser[PORT_ID_LSB+7:PORT_ID_LSB] is overwritten with 8'h00 or 8'h01; all other tuser bits pass through.
  - Accepted beat with tlast=1 -> last_served=x, next state IDLE.
- Output register:
  - If m_axis_tvalid && !m_axis_tready, all m_axis_* hold stable.
  - If m_axis_tready && no new beat is accepted, m_axis_tvalid goes to 0 next cycle.

Latency and throughput:
- One cycle from input acceptance to m_axis_tvalid.
- Full rate (1 beat/cycle) within a packet when m_axis_tready=1.
- Exactly one dead cycle (IDLE) between packets. This dead cycle is required and is checked.

Boundary conditions:
- Granted input drops tvalid mid-packet: the grant is held indefinitely, with no timeout and no switch.
- Single-beat packet (tvalid && tlast on the first beat): accepted, then IDLE.
- Backpressure on the last beat: tlast is held in the output register; the FSM is already in IDLE and may re-grant, but no beat is accepted until the register frees.
- A port continuously valid while the other is also valid: packets strictly alternate.
- Counter width rule: 32-bit wrap-around at 2^32.

Optional Feature:
Macro: BKD_PKT_ARB_STATS_EN
- Defined: pkt_cnt0/pkt_cnt1 increment by 1 on each accepted tlast beat of the respective port (input side). Reset to 0 and wrap at 0xFFFFFFFF -> 0.
- Undefined: pkt_cnt0/pkt_cnt1 are tied to 32'h0 with no counter flops; the ports remain present.

Decomposition:
- Shared package bkd_pkg holds:
  - state encodings (IDLE/GNT0/GNT1, one-hot 3 bit);
  - AXIS widths (DATA_W=64, STRB_W=8, USER_W=128);
  - TUSER_LEN_MSB=15;
  - port id constants 8'h00 and 8'h01.
- One natural sub-module is axis_reg_slice: the single-stage output register with the ready equation, reusable elsewhere on backend paths.

Test Plan:
1. Reset then only s0 sends 3-beat packet (tdata 0x11,0x22,0x33, tlast on 3rd, tuser[15:0]=24), m_axis_tready=1:
   - m beats match, one cycle latency;
   - m_axis_tuser[23:16]=0x00 and [15:0]=24;
   - s1_axis_tready stays 0.
2. Both ports continuously valid with 2-beat packets, m_axis_tready=1:
   - order on m is p0,p1,p0,p1;
   - exactly one gap cycle between packets;
   - tuser[23:16] alternates 0x00/0x01.
3. m_axis_tready toggles 1010 during a 4-beat s1 packet:
   - no beat is lost or duplicated;
   - m_* stable while tready=0;
   - s1_axis_tready=0 whenever the output register is full and m_axis_tready=0.
4. s0 drops tvalid for 5 cycles mid-packet while s1 is valid:
   - s1_axis_tready stays 0 throughout;
   - the s0 packet completes, then s1 is granted.
5. rst asserted during the 2nd beat of a 4-beat packet:
   - next cycle all outputs are 0 and the FSM is IDLE;
   - a subsequent tie grants port 0 first.
6. With BKD_PKT_ARB_STATS_EN, send 5 p0 and 3 p1 packets: pkt_cnt0=5, pkt_cnt1=3.
   - Without the macro, both read 0.
